voice_mix_sched: RTL and testbench
==================================

Name: voice_mix_sched

Overview:
- Per-frame scheduler that shares one accumulator between NUM_VOICES voice generators.
- On each audio-frame tick it polls every enabled voice in fixed index order and sums the returned L/R samples in a widened accumulator.
- It saturates the sums to BITWIDTH and presents them as the stereo sample pair for the I2S transmitter's wave_in_l/wave_in_r.
- Runs entirely in the ctl_clk domain; the frame tick is produced upstream from the aud_clk edge.

Parameters:
- NUM_VOICES, 8: number of voice requesters, 2..16.
- BITWIDTH, 24: sample width, signed two's complement.
- TIMEOUT, 64: ctl_clk cycles to wait for voice_valid before the voice is skipped.

Ports:
- ctl_clk  in  1  control clock; all logic is on its rising edge.
- ctl_rst  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse marking the start of an audio frame.
- voice_en  in  NUM_VOICES  per-voice enable mask, sampled at frame start.
- voice_sel  out  clog2(NUM_VOICES)  index of the voice being polled.
- voice_start  out  1  one-cycle request strobe to voice[voice_sel].
- voice_valid  in  1  response strobe; voice_l and voice_r are valid in this cycle.
- voice_l  in  BITWIDTH  left sample from the selected voice.
- voice_r  in  BITWIDTH  right sample from the selected voice.
- wave_l  out  BITWIDTH  mixed, saturated left sample (to i2s_tx_mod).
- wave_r  out  BITWIDTH  mixed, saturated right sample.
- sample_valid  out  1  one-cycle pulse when wave_l/wave_r update.
- busy  out  1  high from frame acceptance until DONE completes.
- err_clr  in  1  clears the sticky error flags.
- overrun_err  out  1  sticky: frame_tick arrived while busy.
- timeout_err  out  1  sticky: a voice exceeded TIMEOUT.

Behaviour:
- Reset (ctl_rst==0 at a clock edge):
  - state=IDLE.
  - All outputs 0, including wave_l, wave_r and both error flags.
  - Accumulators, index and timeout counter cleared.
  - Reset mid-frame aborts the frame with no sample_valid.
- Accumulator width is ACC_W = BITWIDTH + clog2(NUM_VOICES). Inputs are sign-extended before adding.
- IDLE: on frame_tick, clear both accumulators, latch voice_en into en_q, set idx=0, go to ISSUE.
- ISSUE:
  - If en_q[idx]=1: assert voice_start for exactly 1 cycle with voice_sel=idx, clear the timeout counter, go to WAIT.
  - If en_q[idx]=0: go to NEXT; no strobe is issued.
- WAIT:
  - voice_valid=1: add voice_l/voice_r into the accumulators at this edge, go to NEXT.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without valid: set timeout_err, add nothing, go to NEXT.
  - voice_valid seen in any state other than WAIT is ignored.
- NEXT: if idx==NUM_VOICES-1 go to DONE; otherwise idx+1 and go to ISSUE.
- DONE:
  - Saturate each accumulator: >2^(BITWIDTH-1)-1 gives max positive; <-2^(BITWIDTH-1) gives min negative.
  - Register the results to wave_l/wave_r, pulse sample_valid for 1 cycle, return to IDLE.
  - wave_l/wave_r hold their value until the next DONE.
- voice_sel holds idx in every state and is 0 in IDLE.
- busy=1 in every state except IDLE.
- Latency, all voices enabled and valid the cycle after the strobe: frame_tick → sample_valid = 3*NUM_VOICES+2 cycles.
- All voices disabled: the pass still runs. Result is 0 with sample_valid, and voice_start never asserts.
- frame_tick while busy: the tick is ignored, overrun_err is set, and the current frame completes normally.
- frame_tick in the same cycle as DONE counts as busy and is an overrun.
- Sticky flags clear when err_clr=1. If a set and err_clr occur in the same cycle, the set wins.

Optional Feature:
- Macro: VOICE_MIX_MASTER_GAIN_EN.
- Defined:
  - Adds input master_shift[3:0].
  - The accumulators are arithmetically right-shifted by master_shift (latched at frame start) before saturation in DONE.
  - Adds one cycle of latency.
- Undefined: the port is absent, there is no shift, and latency is as above.

Decomposition:
- Package voice_mix_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, NEXT, DONE);
  - a clog2 constant function;
  - the ACC_W derivation;
  - saturation limit constants.
- One sub-module: sat_clip, a combinational ACC_W→BITWIDTH signed saturator, instantiated twice for L and R.

Test Plan:
- NUM_VOICES=8, all enabled, voice k returns L=k*0x1000, R=-k*0x1000 one cycle after the strobe → wave_l=0x01C000, wave_r=0xFE4000, sample_valid 26 cycles after frame_tick.
- Voices 0 and 1 return L=0x600000, R=0xA00000, others disabled → wave_l=0x7FFFFF, wave_r=0x800000; exactly 2 voice_start pulses.
- Voice 3 never asserts valid, others return 0x10 → timeout_err=1, wave_l=0x70; err_clr pulse → flag 0.
- Second frame_tick 5 cycles after the first → overrun_err=1, exactly one sample_valid, result unaffected.
- ctl_rst low during WAIT of voice 4 → no sample_valid, all outputs 0; the next frame_tick produces a correct full mix.
- With VOICE_MIX_MASTER_GAIN_EN and master_shift=2, two voices of 0x600000 → wave_l=0x300000.

Source files
------------

// File: rtl/voice_mix_pkg.sv
// Shared types and constant helpers for the voice mixer scheduler.
// The SCALE state exists only when VOICE_MIX_MASTER_GAIN_EN is defined.
package voice_mix_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
`ifdef VOICE_MIX_MASTER_GAIN_EN
        ,
        SCALE = 3'd5
`endif
    } mix_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // Guard bits let every voice at full scale add up without wrapping.
    function automatic int acc_width(input int num_voices, input int bitwidth);
        return bitwidth + clog2(num_voices);
    endfunction

    function automatic longint sat_max(input int width);
        return (64'sd1 <<< (width - 32'sd1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(64'sd1 <<< (width - 32'sd1));
    endfunction

endpackage

// File: rtl/voice_mix_sched_sat_clip.sv
// Combinational signed saturator from a wide accumulator to the sample width.
module sat_clip
    import voice_mix_pkg::*;
#(
    parameter int IN_W  = 27,
    parameter int OUT_W = 24
) (
    input  logic signed [IN_W-1:0] din,
    output logic        [OUT_W-1:0] dout
);

    localparam logic signed [IN_W-1:0] MAX_V = IN_W'(sat_max(OUT_W));
    localparam logic signed [IN_W-1:0] MIN_V = IN_W'(sat_min(OUT_W));

    // Clamp to the representable range of the narrower signed word.
    always_comb begin
        dout = din[OUT_W-1:0];
        if (din > MAX_V) begin
            dout = MAX_V[OUT_W-1:0];
        end else if (din < MIN_V) begin
            dout = MIN_V[OUT_W-1:0];
        end else begin
            dout = din[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/voice_mix_sched.sv
// Per-frame scheduler polling NUM_VOICES voices and mixing them into one
// saturated stereo sample. Optional master shift: VOICE_MIX_MASTER_GAIN_EN.
module voice_mix_sched
    import voice_mix_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int BITWIDTH   = 24,
    parameter int TIMEOUT    = 64
) (
    input  logic                         ctl_clk,
    input  logic                         ctl_rst,
    input  logic                         frame_tick,
    input  logic [NUM_VOICES-1:0]        voice_en,
`ifdef VOICE_MIX_MASTER_GAIN_EN
    input  logic [3:0]                   master_shift,
`endif
    output logic [clog2(NUM_VOICES)-1:0] voice_sel,
    output logic                         voice_start,
    input  logic                         voice_valid,
    input  logic [BITWIDTH-1:0]          voice_l,
    input  logic [BITWIDTH-1:0]          voice_r,
    output logic [BITWIDTH-1:0]          wave_l,
    output logic [BITWIDTH-1:0]          wave_r,
    output logic                         sample_valid,
    output logic                         busy,
    input  logic                         err_clr,
    output logic                         overrun_err,
    output logic                         timeout_err
);

    localparam int SEL_W = clog2(NUM_VOICES);
    localparam int ACC_W = acc_width(NUM_VOICES, BITWIDTH);
    localparam int GUARD = ACC_W - BITWIDTH;
    localparam int TO_W  = clog2(TIMEOUT + 1);

    mix_state_e              state_r, state_nxt;
    logic [SEL_W-1:0]        idx_r, idx_nxt;
    logic [NUM_VOICES-1:0]   en_r, en_nxt;
    logic [TO_W-1:0]         cnt_r, cnt_nxt;
    logic signed [ACC_W-1:0] acc_l_r, acc_l_nxt, acc_r_r, acc_r_nxt;
    logic signed [ACC_W-1:0] ext_l_s, ext_r_s;
    logic [BITWIDTH-1:0]     sat_l_s, sat_r_s;
    logic [BITWIDTH-1:0]     wave_l_r, wave_l_nxt, wave_r_r, wave_r_nxt;
    logic                    start_r, start_nxt;
    logic                    sv_r, sv_nxt;
    logic                    busy_r;
    logic [SEL_W-1:0]        sel_r;
    logic                    ov_r, ov_set_s;
    logic                    to_r, to_set_s;
`ifdef VOICE_MIX_MASTER_GAIN_EN
    logic [3:0]              shift_r, shift_nxt;
`endif

    assign ext_l_s = {{GUARD{voice_l[BITWIDTH-1]}}, voice_l};
    assign ext_r_s = {{GUARD{voice_r[BITWIDTH-1]}}, voice_r};

    sat_clip #(.IN_W(ACC_W), .OUT_W(BITWIDTH)) u_sat_l (.din(acc_l_r), .dout(sat_l_s));
    sat_clip #(.IN_W(ACC_W), .OUT_W(BITWIDTH)) u_sat_r (.din(acc_r_r), .dout(sat_r_s));

    // Next-state, datapath and strobe computation for the polling FSM.
    always_comb begin
        state_nxt  = state_r;
        idx_nxt    = idx_r;
        en_nxt     = en_r;
        cnt_nxt    = cnt_r;
        acc_l_nxt  = acc_l_r;
        acc_r_nxt  = acc_r_r;
        wave_l_nxt = wave_l_r;
        wave_r_nxt = wave_r_r;
        sv_nxt     = 1'b0;
        to_set_s   = 1'b0;
        ov_set_s   = frame_tick && (state_r != IDLE);
`ifdef VOICE_MIX_MASTER_GAIN_EN
        shift_nxt  = shift_r;
`endif
        case (state_r)
            IDLE: begin
                idx_nxt = {SEL_W{1'b0}};
                if (frame_tick) begin
                    acc_l_nxt = {ACC_W{1'b0}};
                    acc_r_nxt = {ACC_W{1'b0}};
                    en_nxt    = voice_en;
                    state_nxt = ISSUE;
`ifdef VOICE_MIX_MASTER_GAIN_EN
                    shift_nxt = master_shift;
`endif
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                cnt_nxt = {TO_W{1'b0}};
                if (en_r[idx_r]) begin
                    state_nxt = WAIT;
                end else begin
                    state_nxt = NEXT;
                end
            end
            WAIT: begin
                if (voice_valid) begin
                    acc_l_nxt = acc_l_r + ext_l_s;
                    acc_r_nxt = acc_r_r + ext_r_s;
                    state_nxt = NEXT;
                end else if (cnt_r == TO_W'(TIMEOUT - 1)) begin
                    to_set_s  = 1'b1;
                    state_nxt = NEXT;
                end else begin
                    cnt_nxt = cnt_r + TO_W'(1'b1);
                end
            end
            NEXT: begin
                if (idx_r == SEL_W'(NUM_VOICES - 1)) begin
`ifdef VOICE_MIX_MASTER_GAIN_EN
                    state_nxt = SCALE;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    idx_nxt   = idx_r + SEL_W'(1'b1);
                    state_nxt = ISSUE;
                end
            end
`ifdef VOICE_MIX_MASTER_GAIN_EN
            SCALE: begin
                acc_l_nxt = acc_l_r >>> shift_r;
                acc_r_nxt = acc_r_r >>> shift_r;
                state_nxt = DONE;
            end
`endif
            DONE: begin
                wave_l_nxt = sat_l_s;
                wave_r_nxt = sat_r_s;
                sv_nxt     = 1'b1;
                idx_nxt    = {SEL_W{1'b0}};
                state_nxt  = IDLE;
            end
            default: begin
                idx_nxt   = {SEL_W{1'b0}};
                state_nxt = IDLE;
            end
        endcase
        // Strobe is registered so it is high for exactly the ISSUE cycle.
        start_nxt = (state_nxt == ISSUE) && en_nxt[idx_nxt];
    end

    // State, datapath and registered outputs; synchronous active-low reset.
    always_ff @(posedge ctl_clk) begin
        if (!ctl_rst) begin
            state_r  <= IDLE;
            idx_r    <= {SEL_W{1'b0}};
            en_r     <= {NUM_VOICES{1'b0}};
            cnt_r    <= {TO_W{1'b0}};
            acc_l_r  <= {ACC_W{1'b0}};
            acc_r_r  <= {ACC_W{1'b0}};
            wave_l_r <= {BITWIDTH{1'b0}};
            wave_r_r <= {BITWIDTH{1'b0}};
            start_r  <= 1'b0;
            sv_r     <= 1'b0;
            busy_r   <= 1'b0;
            sel_r    <= {SEL_W{1'b0}};
            ov_r     <= 1'b0;
            to_r     <= 1'b0;
`ifdef VOICE_MIX_MASTER_GAIN_EN
            shift_r  <= 4'd0;
`endif
        end else begin
            state_r  <= state_nxt;
            idx_r    <= idx_nxt;
            en_r     <= en_nxt;
            cnt_r    <= cnt_nxt;
            acc_l_r  <= acc_l_nxt;
            acc_r_r  <= acc_r_nxt;
            wave_l_r <= wave_l_nxt;
            wave_r_r <= wave_r_nxt;
            start_r  <= start_nxt;
            sv_r     <= sv_nxt;
            busy_r   <= (state_nxt != IDLE);
            sel_r    <= idx_nxt;
            ov_r     <= ov_set_s | (ov_r & ~err_clr);
            to_r     <= to_set_s | (to_r & ~err_clr);
`ifdef VOICE_MIX_MASTER_GAIN_EN
            shift_r  <= shift_nxt;
`endif
        end
    end

    assign voice_sel    = sel_r;
    assign voice_start  = start_r;
    assign wave_l       = wave_l_r;
    assign wave_r       = wave_r_r;
    assign sample_valid = sv_r;
    assign busy         = busy_r;
    assign overrun_err  = ov_r;
    assign timeout_err  = to_r;

endmodule

// File: tb/tb_voice_mix_sched.sv
// Directed self-checking bench for voice_mix_sched (default 8 voices, 24-bit).
module tb_voice_mix_sched;

    localparam int NV = 8;
`ifdef VOICE_MIX_MASTER_GAIN_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic        ctl_clk = 1'b0;
    logic        ctl_rst;
    logic        frame_tick;
    logic [7:0]  voice_en;
    logic [2:0]  voice_sel;
    logic        voice_start;
    logic        voice_valid = 1'b0;
    logic [23:0] voice_l = 24'd0;
    logic [23:0] voice_r = 24'd0;
    logic [23:0] wave_l, wave_r;
    logic        sample_valid, busy, err_clr, overrun_err, timeout_err;
`ifdef VOICE_MIX_MASTER_GAIN_EN
    logic [3:0]  master_shift;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_starts = 0;
    int n_sv = 0;

    logic [23:0] vl [16];
    logic [23:0] vr [16];
    logic [15:0] resp_en;
    logic        pend = 1'b0;
    logic [23:0] pend_l = 24'd0;
    logic [23:0] pend_r = 24'd0;

    voice_mix_sched dut (
        .ctl_clk      (ctl_clk),
        .ctl_rst      (ctl_rst),
        .frame_tick   (frame_tick),
        .voice_en     (voice_en),
`ifdef VOICE_MIX_MASTER_GAIN_EN
        .master_shift (master_shift),
`endif
        .voice_sel    (voice_sel),
        .voice_start  (voice_start),
        .voice_valid  (voice_valid),
        .voice_l      (voice_l),
        .voice_r      (voice_r),
        .wave_l       (wave_l),
        .wave_r       (wave_r),
        .sample_valid (sample_valid),
        .busy         (busy),
        .err_clr      (err_clr),
        .overrun_err  (overrun_err),
        .timeout_err  (timeout_err)
    );

    always #5 ctl_clk = ~ctl_clk;

    // Voice model: answers one cycle after a strobe it sees.
    always @(posedge ctl_clk) begin
        #1;
        voice_valid = pend;
        voice_l     = pend_l;
        voice_r     = pend_r;
        pend        = 1'b0;
        if (voice_start === 1'b1 && resp_en[voice_sel] === 1'b1) begin
            pend   = 1'b1;
            pend_l = vl[voice_sel];
            pend_r = vr[voice_sel];
        end
    end

    always @(negedge ctl_clk) begin
        if (voice_start === 1'b1) n_starts++;
        if (sample_valid === 1'b1) n_sv++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ctl_clk);
            #1;
        end
    endtask

    task automatic run_frame(output int lat, output logic got);
        frame_tick = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge ctl_clk);
            #1;
            frame_tick = 1'b0;
            lat = lat + 1;
            if (sample_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 16; k++) begin
            vl[k] = 24'(k * 32'h1000);
            vr[k] = 24'(-(k * 32'h1000));
        end
        resp_en = 16'hFFFF;
    endtask

    initial begin : main
        int lat;
        logic got;
        int s0;
        int v0;
        ctl_rst = 1'b0;
        frame_tick = 1'b0;
        voice_en = 8'h00;
        err_clr = 1'b0;
`ifdef VOICE_MIX_MASTER_GAIN_EN
        master_shift = 4'd0;
`endif
        load_ramp();
        idle(3);
        check_eq("rst_wave_l", 32'(wave_l), 32'h0);
        check_eq("rst_wave_r", 32'(wave_r), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_sv", 32'(sample_valid), 32'h0);
        check_eq("rst_start", 32'(voice_start), 32'h0);
        check_eq("rst_errs", 32'({overrun_err, timeout_err}), 32'h0);
        ctl_rst = 1'b1;
        idle(2);

        // Full ramp mix, all voices enabled.
        voice_en = 8'hFF;
        s0 = n_starts;
        run_frame(lat, got);
        check_eq("t1_done", 32'(got), 32'h1);
        check_eq("t1_latency", 32'(lat), 32'(3 * NV + 2 + EXTRA));
        check_eq("t1_wave_l", 32'(wave_l), 32'h01C000);
        check_eq("t1_wave_r", 32'(wave_r), 32'hFE4000);
        idle(2);
        check_eq("t1_starts", 32'(n_starts - s0), 32'd8);
        check_eq("t1_busy", 32'(busy), 32'h0);

        // Saturation in both directions with two voices.
        vl[0] = 24'h600000; vl[1] = 24'h600000;
        vr[0] = 24'hA00000; vr[1] = 24'hA00000;
        voice_en = 8'h03;
        s0 = n_starts;
        run_frame(lat, got);
        check_eq("t2_done", 32'(got), 32'h1);
        check_eq("t2_wave_l", 32'(wave_l), 32'h7FFFFF);
        check_eq("t2_wave_r", 32'(wave_r), 32'h800000);
        idle(2);
        check_eq("t2_starts", 32'(n_starts - s0), 32'd2);

        // All voices disabled: pass still runs, result zero, no strobes.
        voice_en = 8'h00;
        s0 = n_starts;
        run_frame(lat, got);
        check_eq("t3_done", 32'(got), 32'h1);
        check_eq("t3_latency", 32'(lat), 32'(2 * NV + 2 + EXTRA));
        check_eq("t3_wave_l", 32'(wave_l), 32'h0);
        check_eq("t3_wave_r", 32'(wave_r), 32'h0);
        idle(2);
        check_eq("t3_starts", 32'(n_starts - s0), 32'd0);

        // Voice 3 never answers.
        for (int k = 0; k < 16; k++) begin
            vl[k] = 24'h10;
            vr[k] = 24'h10;
        end
        resp_en = 16'hFFF7;
        voice_en = 8'hFF;
        run_frame(lat, got);
        check_eq("t4_done", 32'(got), 32'h1);
        check_eq("t4_timeout_err", 32'(timeout_err), 32'h1);
        check_eq("t4_overrun_err", 32'(overrun_err), 32'h0);
        check_eq("t4_wave_l", 32'(wave_l), 32'h70);
        check_eq("t4_wave_r", 32'(wave_r), 32'h70);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        idle(1);
        check_eq("t4_cleared", 32'(timeout_err), 32'h0);

        // Second tick five cycles into a frame.
        load_ramp();
        v0 = n_sv;
        frame_tick = 1'b1;
        idle(1);
        frame_tick = 1'b0;
        idle(4);
        frame_tick = 1'b1;
        idle(1);
        frame_tick = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sample_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            idle(1);
        end
        check_eq("t5_done", 32'(got), 32'h1);
        idle(40);
        check_eq("t5_overrun_err", 32'(overrun_err), 32'h1);
        check_eq("t5_sv_count", 32'(n_sv - v0), 32'd1);
        check_eq("t5_wave_l", 32'(wave_l), 32'h01C000);
        check_eq("t5_wave_r", 32'(wave_r), 32'hFE4000);

        // Reset while waiting on voice 4.
        resp_en = 16'hFFEF;
        v0 = n_sv;
        frame_tick = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            idle(1);
            frame_tick = 1'b0;
            if (voice_start === 1'b1 && voice_sel === 3'd4) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("t6_reach_v4", 32'(got), 32'h1);
        idle(2);
        ctl_rst = 1'b0;
        idle(1);
        check_eq("t6_wave_l", 32'(wave_l), 32'h0);
        check_eq("t6_wave_r", 32'(wave_r), 32'h0);
        check_eq("t6_busy", 32'(busy), 32'h0);
        check_eq("t6_sel", 32'(voice_sel), 32'h0);
        check_eq("t6_errs", 32'({overrun_err, timeout_err}), 32'h0);
        ctl_rst = 1'b1;
        idle(5);
        check_eq("t6_no_sv", 32'(n_sv - v0), 32'd0);
        resp_en = 16'hFFFF;
        run_frame(lat, got);
        check_eq("t6_done", 32'(got), 32'h1);
        check_eq("t6_latency", 32'(lat), 32'(3 * NV + 2 + EXTRA));
        check_eq("t6_mix_l", 32'(wave_l), 32'h01C000);
        check_eq("t6_mix_r", 32'(wave_r), 32'hFE4000);

`ifdef VOICE_MIX_MASTER_GAIN_EN
        // Master shift of 2 on two full-scale-ish voices.
        idle(2);
        vl[0] = 24'h600000; vl[1] = 24'h600000;
        vr[0] = 24'hA00000; vr[1] = 24'hA00000;
        voice_en = 8'h03;
        master_shift = 4'd2;
        run_frame(lat, got);
        master_shift = 4'd0;
        check_eq("t7_done", 32'(got), 32'h1);
        check_eq("t7_wave_l", 32'(wave_l), 32'h300000);
        check_eq("t7_wave_r", 32'(wave_r), 32'hD00000);
`endif

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1);
    end

endmodule
